password_check_12bit: RTL and testbench

- Reader side of the 12-bit, three-digit password register bank (digit 0 in bits [11:8], digit 1 in [7:4], digit 2 in [3:0]).
- In verify mode (mode=0), collects three BCD digits from the mod10 selector, one per confirm press.
- Compares the entered code against the stored password. Drives unlock on a match; counts failures and enters a timed alarm lockout after too many misses.
- Sits beside the password writer and shares its mode, mod10 and confirm inputs.

---
 rtl/password_check_12bit.sv | 130 +++++++++++++
 tb/tb_password_check_12bit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/password_check_12bit.sv
// Reader side of the three-digit password bank: collects BCD digits, checks them, unlocks or locks out.
// Optional PASSWORD_BCD_CHECK_EN: ignore confirm rises while mod10 holds a non-BCD value.
module password_check_12bit #(
    parameter int          MAX_TRIES   = 3,
    parameter logic [15:0] OPEN_CYCLES = 16'd50000,
    parameter logic [15:0] LOCK_CYCLES = 16'd60000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [3:0]  mod10,
    input  logic        confirm,
    input  logic [11:0] password,
    output logic        unlock,
    output logic        alarm,
    output logic        fail_pulse,
    output logic [1:0]  digit_idx,
    output logic [1:0]  fail_cnt
);

    typedef enum logic [1:0] {ENTER, CHECK, OPEN, LOCK} state_t;

    localparam logic [1:0] MAX_T = 2'(MAX_TRIES);

    state_t      state, state_n;
    logic        confirm_prev;
    logic [3:0]  entry0, entry1, entry2;
    logic [3:0]  entry0_n, entry1_n, entry2_n;
    logic [15:0] timer, timer_n;
    logic [1:0]  digit_idx_n, fail_cnt_n;
    logic        fail_pulse_n;
    logic        rise, digit_ok;

    assign rise = confirm & ~confirm_prev;

`ifdef PASSWORD_BCD_CHECK_EN
    assign digit_ok = (mod10 <= 4'd9);
`else
    assign digit_ok = 1'b1;
`endif

    always_comb begin
        state_n      = state;
        digit_idx_n  = digit_idx;
        fail_cnt_n   = fail_cnt;
        entry0_n     = entry0;
        entry1_n     = entry1;
        entry2_n     = entry2;
        timer_n      = timer;
        fail_pulse_n = 1'b0;
        case (state)
            ENTER: begin
                if (mode) begin
                    digit_idx_n = 2'd0;
                end else if (rise && digit_ok) begin
                    case (digit_idx)
                        2'd0:    entry0_n = mod10;
                        2'd1:    entry1_n = mod10;
                        default: entry2_n = mod10;
                    endcase
                    if (digit_idx >= 2'd2) begin
                        digit_idx_n = 2'd0;
                        state_n     = CHECK;
                    end else begin
                        digit_idx_n = digit_idx + 2'd1;
                    end
                end
            end
            CHECK: begin
                if ({entry0, entry1, entry2} == password) begin
                    fail_cnt_n = 2'd0;
                    timer_n    = OPEN_CYCLES - 16'd1;
                    state_n    = OPEN;
                end else begin
                    fail_pulse_n = 1'b1;
                    fail_cnt_n   = fail_cnt + 2'd1;
                    if (fail_cnt + 2'd1 == MAX_T) begin
                        timer_n = LOCK_CYCLES - 16'd1;
                        state_n = LOCK;
                    end else begin
                        state_n = ENTER;
                    end
                end
            end
            OPEN: begin
                if (timer == 16'd0) state_n = ENTER;
                else                timer_n = timer - 16'd1;
            end
            LOCK: begin
                // Lockout is only left by timeout; the miss count restarts with it.
                if (timer == 16'd0) begin
                    fail_cnt_n = 2'd0;
                    state_n    = ENTER;
                end else begin
                    timer_n = timer - 16'd1;
                end
            end
            default: state_n = ENTER;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ENTER;
            confirm_prev <= 1'b0;
            entry0       <= 4'd0;
            entry1       <= 4'd0;
            entry2       <= 4'd0;
            timer        <= 16'd0;
            digit_idx    <= 2'd0;
            fail_cnt     <= 2'd0;
            fail_pulse   <= 1'b0;
            unlock       <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            state        <= state_n;
            confirm_prev <= confirm;
            entry0       <= entry0_n;
            entry1       <= entry1_n;
            entry2       <= entry2_n;
            timer        <= timer_n;
            digit_idx    <= digit_idx_n;
            fail_cnt     <= fail_cnt_n;
            fail_pulse   <= fail_pulse_n;
            unlock       <= (state_n == OPEN);
            alarm        <= (state_n == LOCK);
        end
    end

endmodule

// File: tb/tb_password_check_12bit.sv
// Directed bench for password_check_12bit with a window-based reference model checked every cycle.
module tb_password_check_12bit;

    localparam int          MAX_T  = 3;
    localparam logic [15:0] OPEN_C = 16'd8;
    localparam logic [15:0] LOCK_C = 16'd16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [3:0]  mod10;
    logic        confirm;
    logic [11:0] password;
    logic        unlock, alarm, fail_pulse;
    logic [1:0]  digit_idx, fail_cnt;

    int errors = 0;
    int checks = 0;
    int unlock_tot = 0, alarm_tot = 0, pulse_tot = 0;
    int u0, a0, p0;

    password_check_12bit #(
        .MAX_TRIES  (MAX_T),
        .OPEN_CYCLES(OPEN_C),
        .LOCK_CYCLES(LOCK_C)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .mod10     (mod10),
        .confirm   (confirm),
        .password  (password),
        .unlock    (unlock),
        .alarm     (alarm),
        .fail_pulse(fail_pulse),
        .digit_idx (digit_idx),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edge index c; outputs expressed as windows of edges relative to the CHECK edge.
    int         c = 0;
    bit         prev = 1'b0;
    logic [3:0] q[$];
    logic [11:0] code;
    int active_from = 0, check_at = -1, pulse_at = -1, fails = 0;
    int o_s = -1, o_e = -1, l_s = -1, l_e = -1;
    bit m_ok;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            c = 0; prev = 1'b0; q.delete();
            active_from = 0; check_at = -1; pulse_at = -1; fails = 0;
            o_s = -1; o_e = -1; l_s = -1; l_e = -1;
        end else begin
            bit r;
            c++;
            r = confirm && !prev;
            prev = confirm;
`ifdef PASSWORD_BCD_CHECK_EN
            m_ok = (mod10 <= 4'd9);
`else
            m_ok = 1'b1;
`endif
            if (c == check_at) begin
                if (code == password) begin
                    fails = 0;
                    o_s = c; o_e = c + int'(OPEN_C) - 1;
                    active_from = c + int'(OPEN_C) + 1;
                end else begin
                    fails++;
                    pulse_at = c;
                    if (fails == MAX_T) begin
                        l_s = c; l_e = c + int'(LOCK_C) - 1;
                        active_from = c + int'(LOCK_C) + 1;
                    end else begin
                        active_from = c + 1;
                    end
                end
            end else if (c >= active_from) begin
                if (mode) q.delete();
                else if (r && m_ok) begin
                    q.push_back(mod10);
                    if (q.size() == 3) begin
                        code = {q[0], q[1], q[2]};
                        q.delete();
                        check_at = c + 1;
                        active_from = c + 2;
                    end
                end
            end
            if (l_e >= 0 && c == l_e + 1) fails = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("unlock",     unlock,     int'(c >= o_s && c <= o_e));
            chk("alarm",      alarm,      int'(c >= l_s && c <= l_e));
            chk("fail_pulse", fail_pulse, int'(c == pulse_at));
            chk("digit_idx",  digit_idx,  q.size());
            chk("fail_cnt",   fail_cnt,   fails);
            unlock_tot += int'(unlock);
            alarm_tot  += int'(alarm);
            pulse_tot  += int'(fail_pulse);
        end
    end

    task automatic press(input logic [3:0] d);
        mod10 = d; confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
        @(negedge clk);
    endtask

    task automatic code3(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        press(a); press(b); press(d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; mode = 1'b0; mod10 = 4'd0; confirm = 1'b0; password = 12'h427;
        repeat (3) @(negedge clk);
        chk("rst_unlock", unlock, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_pulse", fail_pulse, 0);
        chk("rst_idx", digit_idx, 0);
        chk("rst_fcnt", fail_cnt, 0);
        rst = 1'b1;
        @(negedge clk);

        // Right code
        u0 = unlock_tot;
        code3(4'd4, 4'd2, 4'd7);
        repeat (14) @(negedge clk);
        chk("right_open_len", unlock_tot - u0, 8);
        chk("right_idx", digit_idx, 0);
        chk("right_fcnt", fail_cnt, 0);

        // Wrong code
        u0 = unlock_tot; p0 = pulse_tot;
        code3(4'd4, 4'd2, 4'd8);
        repeat (4) @(negedge clk);
        chk("wrong_pulse_len", pulse_tot - p0, 1);
        chk("wrong_fcnt", fail_cnt, 1);
        chk("wrong_unlock", unlock_tot - u0, 0);
        chk("wrong_idx", digit_idx, 0);
        code3(4'd4, 4'd2, 4'd7);
        repeat (12) @(negedge clk);
        chk("clear_fcnt", fail_cnt, 0);

        // Lockout, correct code during alarm is ignored
        a0 = alarm_tot;
        repeat (3) begin
            code3(4'd4, 4'd2, 4'd8);
            @(negedge clk);
        end
        chk("lock_alarm_on", alarm, 1);
        u0 = unlock_tot;
        code3(4'd4, 4'd2, 4'd7);
        chk("lock_idx", digit_idx, 0);
        repeat (25) @(negedge clk);
        chk("lock_alarm_len", alarm_tot - a0, 16);
        chk("lock_no_unlock", unlock_tot - u0, 0);
        chk("lock_fcnt_after", fail_cnt, 0);
        u0 = unlock_tot;
        code3(4'd4, 4'd2, 4'd7);
        repeat (12) @(negedge clk);
        chk("post_lock_unlock", unlock_tot - u0, 8);

        // Mode interaction
        press(4'd4); press(4'd2);
        chk("mode_idx2", digit_idx, 2);
        mode = 1'b1;
        @(negedge clk);
        chk("mode_idx0", digit_idx, 0);
        press(4'd5);
        chk("mode_nocap", digit_idx, 0);
        mode = 1'b0;
        u0 = unlock_tot;
        code3(4'd4, 4'd2, 4'd7);
        repeat (12) @(negedge clk);
        chk("mode_unlock", unlock_tot - u0, 8);

        // Held confirm gives one rise
        mod10 = 4'd4; confirm = 1'b1;
        repeat (20) @(negedge clk);
        confirm = 1'b0;
        @(negedge clk);
        chk("hold_idx", digit_idx, 1);
        u0 = unlock_tot;
        press(4'd2); press(4'd7);
        repeat (12) @(negedge clk);
        chk("hold_unlock", unlock_tot - u0, 8);

        // Non-BCD digit
        press(4'hC);
`ifdef PASSWORD_BCD_CHECK_EN
        chk("bcd_idx", digit_idx, 0);
`else
        chk("bcd_idx", digit_idx, 1);
`endif
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Asynchronous reset during lockout
        repeat (3) begin
            code3(4'd1, 4'd1, 4'd1);
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk("midlock_alarm", alarm, 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_alarm", alarm, 0);
        chk("arst_fcnt", fail_cnt, 0);
        chk("arst_idx", digit_idx, 0);
        chk("arst_unlock", unlock, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
